pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer. It generalises the fixed-width stall/flush stage register (PC plus instruction between fetch and decode) to any payload width. It adds backpressure without data loss, flush-to-bubble, and a saturating stall counter. It sits between any two pipeline stages, for example IF→ID or ID→EX, and carries the concatenated stage payload.

## Interface
- DATA_W, 64: payload width in bits; PC and instruction concatenated for IF→ID.
- BUBBLE_VAL, {DATA_W{1'b0}}: value driven on data_o whenever valid_o is 0.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream payload valid.
- ready_o  output  1  stage can accept; equals "skid entry empty".
- data_i  input  DATA_W  upstream payload.
- valid_o  output  1  output entry valid.
- ready_i  input  1  downstream accepts.
- data_o  output  DATA_W  output payload; BUBBLE_VAL when valid_o is 0.
- flush_i  input  1  discard all held entries (branch/exception kill).
- stall_cnt_o  output  CNT_W  saturating count of cycles with valid_o=1 and ready_i=0.

## Operation
- Definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Storage: main register (drives data_o) and skid register.
- States:
  - EMPTY: no entries; valid_o=0, ready_o=1.
  - ONE: main valid, skid empty; valid_o=1, ready_o=1.
  - FULL: main and skid valid; valid_o=1, ready_o=0.
- Transitions (flush_i=0):
  - EMPTY: in_fire → ONE, main<=data_i. Otherwise stay in EMPTY.
  - ONE: in_fire & out_fire → ONE, main<=data_i.
  - ONE: in_fire only → FULL, skid<=data_i.
  - ONE: out_fire only → EMPTY.
  - ONE: neither → hold.
  - FULL: out_fire → ONE, main<=skid. Otherwise hold. in_fire is impossible in FULL.
- Flush priority:
  - flush_i=1 → next state EMPTY from any state. Both entries are invalidated.
  - An in_fire in the same cycle is consumed and dropped.
  - An out_fire in the same cycle still counts as delivered downstream.
- Reset: rst_i dominates flush_i and all handshakes. State becomes EMPTY and stall_cnt_o becomes 0.
- Data masking: data_o = valid_o ? main : BUBBLE_VAL. The payload contents of main and skid need not be cleared.
- Stall counter:
  - Increments by 1 on each cycle with valid_o=1 & ready_i=0.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Cleared only by rst_i; flush does not clear it.
- Ordering: entries leave strictly in acceptance order. Nothing is duplicated or lost except by flush.

## Timing
- Reset values: valid_o=0, ready_o=1, data_o=BUBBLE_VAL, stall_cnt_o=0.
- Latency: 1 cycle from in_fire to valid_o=1 with that payload.
- Throughput: one transfer per cycle while ready_i=1.
- ready_o and valid_o are driven purely from registered state. There is no combinational path from ready_i, valid_i or flush_i to any output.
- ready_o falls the cycle after the skid fills. It rises the cycle after an out_fire in FULL.
- Flush takes effect at the edge it is sampled: valid_o=0 and ready_o=1 in the following cycle.
- valid_i may deassert at any time. Once valid_o=1, data_o is stable until out_fire, flush or reset.

## Test plan
- Reset then stream:
  - Stimulus: assert rst_i for 2 cycles, then drive data 0x1…0x5 with valid_i=1, ready_i=1 continuously.
  - Response: after reset, valid_o=0, data_o=0 and ready_o=1.
  - Response: data_o shows 0x1…0x5 on consecutive cycles, 1 cycle after each input; stall_cnt_o stays 0.
- Backpressure with skid:
  - Stimulus: send A, B, C with ready_i=0 from the cycle A appears on data_o, holding for 4 cycles, then ready_i=1.
  - Response: B is captured in the skid and ready_o=0 while C is held upstream.
  - Response: output order is A, B, C with no loss; stall_cnt_o=4.
- Flush in FULL:
  - Stimulus: fill to FULL (A main, B skid), then pulse flush_i with ready_i=0.
  - Response: next cycle valid_o=0, data_o=BUBBLE_VAL and ready_o=1. A and B never appear.
  - Response: the next input D emerges 1 cycle after acceptance.
- Flush with simultaneous in_fire:
  - Stimulus: in ONE, drive valid_i=1 with E and flush_i=1 in the same cycle.
  - Response: state becomes EMPTY and E is dropped.
- Reset beats flush and handshake:
  - Stimulus: in FULL with stall_cnt_o=7, assert rst_i and flush_i together, with valid_i=1 and ready_i=1.
  - Response: state EMPTY, stall_cnt_o=0, ready_o=1.
- Counter saturation:
  - Stimulus: with CNT_W=3, hold valid_o=1 and ready_i=0 for 10 cycles.
  - Response: stall_cnt_o reaches 7 and stays at 7.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Pipeline-stage register with a valid/ready handshake and a one-entry
//   skid buffer. Payloads leave in the order they were accepted. A flush
//   turns the stage into a bubble. A saturating counter tracks the cycles
//   in which the stage held valid data while downstream was not ready.
//
// Parameters
//   DATA_W      payload width (e.g. PC and instruction for IF->ID)
//   BUBBLE_VAL  value shown on data_o whenever valid_o is 0
//   CNT_W       stall counter width
//
// Ports
//   clk          rising-edge clock
//   rst_i        synchronous active-high reset (dominates everything)
//   valid_i      upstream payload valid
//   ready_o      stage can accept (skid entry empty)
//   data_i       upstream payload
//   valid_o      output entry valid
//   ready_i      downstream accepts
//   data_o       output payload, BUBBLE_VAL when valid_o is 0
//   flush_i      discard all held entries
//   stall_cnt_o  saturating count of cycles with valid_o=1 and ready_i=0
module pipe_stage_buf #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Both handshake outputs decode only the registered state, so no input
  // has a combinational path to any output.
  assign valid_o = (state != EMPTY);
  assign ready_o = (state != FULL);

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so a new payload cannot arrive in this state.
        if (out_fire) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase

    // A flush wins over the handshake. An accepted input is dropped, and an
    // output taken in the same cycle has already been delivered downstream.
    if (flush_i) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Payload registers are not reset. valid_o masks them, so stale contents
  // are never visible on data_o.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= data_i;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= data_i;
    end
  end

  // Counts stalled cycles and holds at all-ones. Only reset clears it; a
  // flush leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign data_o      = valid_o ? main_q : BUBBLE_VAL;

endmodule
